mod_addsub_serial: RTL

- Limb-serial modular adder/subtractor: result = (a + b) mod P or (a - b) mod P for 256-bit field operands.
- Sits directly downstream of the integer add/sub stage in the field-arithmetic datapath.
- Produces the raw sum/difference with carry/borrow, then applies the conditional ±P correction the integer adder lacks.
- Operates W bits per cycle to trade latency for area, with valid/ready handshakes on both sides.

---
 rtl/modarith_pkg.sv | 20 ++
 rtl/limb_addsub.sv | 15 +
 rtl/mod_addsub_serial.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/modarith_pkg.sv
// Shared definitions for the limb-serial field-arithmetic blocks.
package modarith_pkg;

    // Sequencer states of the serial modular add/sub
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Curve25519 field prime, 2^255 - 19
    localparam logic [255:0] P25519 = (256'd1 << 255) - 256'd19;

    // Number of W-bit limbs in an N-bit operand
    function automatic int limb_count(input int n, input int w);
        return n / w;
    endfunction

endpackage

// File: rtl/limb_addsub.sv
// W-bit adder with carry in/out; the single arithmetic unit shared by both passes.
module limb_addsub #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    // Widen to W+1 bits so the top bit is the carry out
    assign {o_cout, o_sum} = {1'b0, i_x} + {1'b0, i_y} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/mod_addsub_serial.sv
// Limb-serial (a +/- b) mod P. Pass 1 forms the raw sum/difference, pass 2
// forms the +/-P corrected value; the final edge picks one of the two.
module mod_addsub_serial
    import modarith_pkg::*;
#(
    parameter int            N = 256,
    parameter int            W = 64,
    parameter logic [N-1:0]  P = N'(P25519)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);

    localparam int L  = limb_count(N, W);
    localparam int CW = (L > 1) ? $clog2(L) : 1;

    if (N % W != 0) begin : g_bad_limb_width
        $error("mod_addsub_serial: N must be a multiple of W");
    end

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_a;        // operand a in pass 1, collects t in pass 2
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_s;        // raw sum/difference, rotated through in pass 2
    logic           r_op;
    logic           r_c;
    logic           r_c1;
    logic           r_out_valid;
    logic [N-1:0]   r_result;

    logic [W-1:0]   w_x;
    logic [W-1:0]   w_y;
    logic [W-1:0]   w_p_limb;
    logic [W-1:0]   w_sum;
    logic           w_cout;
    logic           w_last;
    logic [N-1:0]   w_t_full;
    logic [N-1:0]   w_s_full;
    logic           w_take_t;

    assign in_ready  = (r_state == IDLE) & rst_n;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    // Operand muxing for the shared limb adder: a +/- b in pass 1, s -/+ P in pass 2
    always_comb begin
        w_p_limb = P[int'(r_cnt) * W +: W];
        if (r_state == PASS2) begin
            w_x = r_s[W-1:0];
            w_y = r_op ? w_p_limb : ~w_p_limb;
        end else begin
            w_x = r_a[W-1:0];
            w_y = r_b[W-1:0] ^ {W{r_op}};
        end
    end

    limb_addsub #(.W(W)) u_limb_addsub (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_cin  (r_c),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_last   = (r_cnt == CW'(L - 1));
    // Full-width views as they will look after the last pass-2 shift
    assign w_t_full = {w_sum, r_a[N-1:W]};
    assign w_s_full = {r_s[W-1:0], r_s[N-1:W]};
    // add: subtract P if the sum overflowed or s >= P; sub: add P back on borrow
    assign w_take_t = r_op ? ~r_c1 : (r_c1 | w_cout);

    // Sequencer, limb datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_op        <= 1'b0;
            r_c         <= 1'b0;
            r_c1        <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_c     <= op;
                        r_cnt   <= '0;
                        r_state <= PASS1;
                    end
                end
                PASS1: begin
                    r_a   <= r_a >> W;
                    r_b   <= r_b >> W;
                    r_s   <= {w_sum, r_s[N-1:W]};
                    r_c   <= w_cout;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        r_c1    <= w_cout;
                        // add needs s + ~P + 1, sub needs s + P + 0
                        r_c     <= ~r_op;
                        r_state <= PASS2;
                    end
                end
                PASS2: begin
                    r_s   <= w_s_full;
                    r_a   <= w_t_full;
                    r_c   <= w_cout;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        r_result    <= w_take_t ? w_t_full : w_s_full;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
